lsu_sram_ctrl: RTL and testbench
================================

// Module: lsu_sram_ctrl
// PURPOSE
// Sequences the single-port data SRAM on behalf of the control unit's load/store path.
// Accepts a word-level access (rd_en/wr_en, address, write data, byte mask) and runs a
// fixed-wait-state SRAM cycle. Returns a one-cycle ack; the control unit holds pc_sel=10 (stall) until then.
// Sits between control_unit/ALU outputs and the SRAM macro; read data goes to the load-extend logic.
// PARAMETERS
// ADDR_W      14  SRAM word-address width (depth = 2**ADDR_W words of 32 bits)
// WAIT_CYCLES  1  extra SRAM wait states per access (0..15)
// PORTS
// clk         in   1       core clock; all state changes on rising edge
// rst_n       in   1       asynchronous active-low reset
// rd_en       in   1       load request (level, held until ack)
// wr_en       in   1       store request (level, held until ack)
// addr        in   32      byte address from ALU; bits [1:0] ignored
// wdata       in   32      store data (rs2)
// bmask       in   4       store byte enables, bit i = byte lane i
// rdata       out  32      word read from SRAM, valid from ack cycle until next read completes
// ack         out  1       one-cycle completion pulse
// err         out  1       one-cycle pulse with ack: address out of range
// sram_addr   out  ADDR_W  word address = addr[ADDR_W+1:2]
// sram_wdata  out  32      write data to SRAM
// sram_bmask  out  4       byte write enables to SRAM
// sram_ce_n   out  1       chip enable, active low
// sram_we_n   out  1       write enable, active low
// sram_rdata  in   32      SRAM read data, valid in last ACCESS cycle
// BEHAVIOUR
// Reset (async, rst_n=0): state=IDLE, rdata=0, ack=0, err=0, sram_ce_n=1, sram_we_n=1,
//   sram_addr=0, sram_wdata=0, sram_bmask=0, wait counter=0. Reset mid-access aborts it, no ack.
// FSM states IDLE, ACCESS, ACK (registered outputs):
// - IDLE: rd_en|wr_en sampled high -> latch addr/wdata/bmask/op, load cnt=WAIT_CYCLES;
//   in-range -> ACCESS; out-of-range (addr[31:ADDR_W+2]!=0) -> ACK with err=1, SRAM untouched.
// - ACCESS: sram_ce_n=0; sram_we_n=0 for store, 1 for load; addr/wdata/bmask stable throughout.
//   cnt!=0 -> cnt-1, stay. cnt==0 -> load: capture sram_rdata into rdata; -> ACK.
// - ACK: ack=1 (err per latched check) for exactly one cycle, ce_n/we_n=1; -> IDLE unconditionally.
// Latency: request first seen cycle 0 -> ACCESS cycles 1..WAIT_CYCLES+1 -> ack in cycle WAIT_CYCLES+2.
// Requests seen during ACCESS/ACK are ignored (the held request is the one in service);
//   request still high in ACK cycle is not re-accepted; IDLE re-samples the next cycle (back-to-back OK).
// rd_en & wr_en both high: treated as store. Load ignores bmask (full word read; lane select downstream).
// Out-of-range load: rdata forced to 0, err=1. Out-of-range store: no SRAM write, err=1.
// rdata holds its value across stores and idle cycles.
// Request dropped before ack (e.g. flush): access completes and acks anyway; core ignores it.
// TESTING
// 1 Reset: rst_n=0 mid-ACCESS -> next edge-free: ce_n=1, we_n=1, ack=0, rdata=0; no ack after release.
// 2 Store WAIT_CYCLES=1: wr_en, addr=0x10, wdata=0xDEADBEEF, bmask=4'b0011 -> sram_addr=4, we_n=0 for
//   2 cycles, ack at cycle 3; read-back of addr 0x10 returns 0x0000BEEF over prior-zero word.
// 3 Load WAIT_CYCLES=0: rd_en, addr=0x10 -> ack at cycle 2, rdata=SRAM[4], we_n=1 throughout.
// 4 Back-to-back: load then store, request re-asserted cycle after ack -> second ACCESS starts
//   next cycle, exactly two ack pulses.
// 5 Out of range: rd_en, addr=0x0001_0000 (ADDR_W=14) -> ack+err cycle 1, ce_n stays 1, rdata=0.
// 6 Both rd_en&wr_en, addr=0x8 -> store performed (we_n=0), rdata unchanged.

Source files
------------

// File: rtl/lsu_sram_ctrl.sv
// Load/store sequencer for the single-port data SRAM: one word access per request, fixed wait states.
// Ack arrives WAIT_CYCLES+2 cycles after the request is first sampled; an out-of-range address acks one cycle later with err.
module lsu_sram_ctrl #(
   parameter int ADDR_W      = 14,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        bmask,
   output logic [31:0]       rdata,
   output logic              ack,
   output logic              err,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   output logic [3:0]        sram_bmask,
   output logic              sram_ce_n,
   output logic              sram_we_n,
   input  logic [31:0]       sram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] cnt_q;
   logic       is_store_q;
   logic       req;
   logic       out_of_range;
   logic       accept;
   logic       finish;

   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      finish       = 1'b0;
      req          = rd_en | wr_en;
      out_of_range = |(addr >> (ADDR_W + 2));
      case (state_q)
         IDLE: begin
            if (req) begin
               accept  = 1'b1;
               state_d = out_of_range ? ACK : ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               finish  = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         is_store_q <= 1'b0;
         rdata      <= 32'h0;
         ack        <= 1'b0;
         err        <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= 32'h0;
         sram_bmask <= 4'h0;
         sram_ce_n  <= 1'b1;
         sram_we_n  <= 1'b1;
      end else begin
         state_q <= state_d;
         ack     <= 1'b0;
         err     <= 1'b0;
         if (accept) begin
            if (out_of_range) begin
               // SRAM pins are left alone; only a load clobbers rdata.
               ack <= 1'b1;
               err <= 1'b1;
               if (!wr_en) rdata <= 32'h0;
            end else begin
               sram_addr  <= addr[ADDR_W+1:2];
               sram_wdata <= wdata;
               sram_bmask <= bmask;
               is_store_q <= wr_en;
               cnt_q      <= WAIT_INIT;
               sram_ce_n  <= 1'b0;
               sram_we_n  <= ~wr_en;
            end
         end
         if (state_q == ACCESS) begin
            if (finish) begin
               ack       <= 1'b1;
               sram_ce_n <= 1'b1;
               sram_we_n <= 1'b1;
               if (!is_store_q) rdata <= sram_rdata;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed bench: one controller with one wait state, one with none, each wired to a small SRAM model.
module tb_lsu_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_init = 1'b1;
   logic        rd_en1 = 1'b0, wr_en1 = 1'b0, rd_en0 = 1'b0, wr_en0 = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [3:0]  bmask = 4'h0;

   logic [31:0] rdata1, rdata0, sram_wdata1, sram_wdata0, sram_rdata1, sram_rdata0;
   logic        ack1, ack0, err1, err0, ce_n1, ce_n0, we_n1, we_n0;
   logic [13:0] sram_addr1, sram_addr0;
   logic [3:0]  sram_bmask1, sram_bmask0;

   logic [31:0] mem1 [0:63];
   logic [31:0] mem0 [0:63];

   int errors = 0;
   int checks = 0;

   logic        sel;  // 1: observe the one-wait-state instance, 0: the zero-wait one
   logic [31:0] m_rdata;
   logic [13:0] m_sram_addr;
   logic        m_ack, m_err, m_ce_n, m_we_n;

   logic [31:0] o_ack_map, o_err_map, o_ce_map, o_we_map, o_rdata, o_addr;

   always #5 clk = ~clk;

   lsu_sram_ctrl #(.ADDR_W(14), .WAIT_CYCLES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en1), .wr_en(wr_en1), .addr(addr),
      .wdata(wdata), .bmask(bmask), .rdata(rdata1), .ack(ack1), .err(err1),
      .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_bmask(sram_bmask1),
      .sram_ce_n(ce_n1), .sram_we_n(we_n1), .sram_rdata(sram_rdata1));

   lsu_sram_ctrl #(.ADDR_W(14), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en0), .wr_en(wr_en0), .addr(addr),
      .wdata(wdata), .bmask(bmask), .rdata(rdata0), .ack(ack0), .err(err0),
      .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_bmask(sram_bmask0),
      .sram_ce_n(ce_n0), .sram_we_n(we_n0), .sram_rdata(sram_rdata0));

   // SRAM models: asynchronous read while selected, byte-masked write on the clock.
   always_comb sram_rdata1 = !ce_n1 ? mem1[sram_addr1[5:0]] : 32'h0;
   always_comb sram_rdata0 = !ce_n0 ? mem0[sram_addr0[5:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) begin
            mem1[i] <= 32'h0;
            mem0[i] <= 32'h0;
         end
         mem0[4] <= 32'h1234_5678;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (!ce_n1 && !we_n1 && sram_bmask1[b]) mem1[sram_addr1[5:0]][8*b +: 8] <= sram_wdata1[8*b +: 8];
            if (!ce_n0 && !we_n0 && sram_bmask0[b]) mem0[sram_addr0[5:0]][8*b +: 8] <= sram_wdata0[8*b +: 8];
         end
      end
   end

   always_comb begin
      m_rdata     = sel ? rdata1 : rdata0;
      m_sram_addr = sel ? sram_addr1 : sram_addr0;
      m_ack       = sel ? ack1 : ack0;
      m_err       = sel ? err1 : err0;
      m_ce_n      = sel ? ce_n1 : ce_n0;
      m_we_n      = sel ? we_n1 : we_n0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic rd, input logic wr);
      if (sel) begin rd_en1 = rd; wr_en1 = wr; end
      else     begin rd_en0 = rd; wr_en0 = wr; end
   endtask

   // Runs ncyc clocks; bit c of each map is set when the event is seen in cycle c after the
   // request is first sampled. The request is dropped on ack, or swapped for a store when chain=1.
   task automatic observe(input int ncyc, input bit chain);
      bit chained = 1'b0;
      o_ack_map = 0; o_err_map = 0; o_ce_map = 0; o_we_map = 0; o_rdata = 0; o_addr = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         if (!m_ce_n) begin
            if (o_ce_map == 0) o_addr = 32'(m_sram_addr);
            o_ce_map |= 32'(1) << c;
         end
         if (!m_we_n) o_we_map |= 32'(1) << c;
         if (m_err)   o_err_map |= 32'(1) << c;
         if (m_ack) begin
            if (o_ack_map == 0) o_rdata = m_rdata;
            o_ack_map |= 32'(1) << c;
            if (chain && !chained) begin
               chained = 1'b1;
               addr = 32'h20; wdata = 32'hCAFE_F00D; bmask = 4'hF;
               set_req(1'b0, 1'b1);
            end else begin
               set_req(1'b0, 1'b0);
            end
         end
      end
   endtask

   initial begin
      sel = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      chk("rst_ack", {31'h0, ack1}, 32'h0);
      chk("rst_err", {31'h0, err1}, 32'h0);
      chk("rst_ce_we", {30'h0, ce_n1, we_n1}, 32'h3);
      chk("rst_rdata", rdata1, 32'h0);
      chk("rst_sram_addr", {18'h0, sram_addr1}, 32'h0);
      chk("rst_sram_wdata", sram_wdata1, 32'h0);
      chk("rst_sram_bmask", {28'h0, sram_bmask1}, 32'h0);
      rst_n = 1'b1; mem_init = 1'b0;
      @(posedge clk); #1;

      // Partial store, one wait state
      sel = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF; bmask = 4'b0011;
      set_req(1'b0, 1'b1);
      observe(8, 1'b0);
      chk("st_ack_cycle", o_ack_map, 32'h8);
      chk("st_ce_cycles", o_ce_map, 32'h6);
      chk("st_we_cycles", o_we_map, 32'h6);
      chk("st_err", o_err_map, 32'h0);
      chk("st_sram_addr", o_addr, 32'h4);
      chk("st_mem", mem1[4], 32'h0000_BEEF);

      // Read back the same word
      addr = 32'h10; set_req(1'b1, 1'b0);
      observe(8, 1'b0);
      chk("ld1_ack_cycle", o_ack_map, 32'h8);
      chk("ld1_we_cycles", o_we_map, 32'h0);
      chk("ld1_rdata", o_rdata, 32'h0000_BEEF);

      // Load, zero wait states
      sel = 1'b0; addr = 32'h10; set_req(1'b1, 1'b0);
      observe(6, 1'b0);
      chk("ld0_ack_cycle", o_ack_map, 32'h4);
      chk("ld0_ce_cycles", o_ce_map, 32'h2);
      chk("ld0_we_cycles", o_we_map, 32'h0);
      chk("ld0_rdata", o_rdata, 32'h1234_5678);

      // Back-to-back load then store; store held through the ACK cycle must not be taken early
      addr = 32'h10; set_req(1'b1, 1'b0);
      observe(10, 1'b1);
      chk("b2b_ack_cycles", o_ack_map, 32'h24);
      chk("b2b_ce_cycles", o_ce_map, 32'h12);
      chk("b2b_we_cycles", o_we_map, 32'h10);
      chk("b2b_load_rdata", o_rdata, 32'h1234_5678);
      chk("b2b_mem", mem0[8], 32'hCAFE_F00D);
      chk("b2b_rdata_hold", rdata0, 32'h1234_5678);

      // Out-of-range store: no SRAM activity, rdata kept
      addr = 32'h8000_0000; wdata = 32'h5555_5555; set_req(1'b0, 1'b1);
      observe(5, 1'b0);
      chk("oor_st_ack", o_ack_map, 32'h2);
      chk("oor_st_err", o_err_map, 32'h2);
      chk("oor_st_ce", o_ce_map, 32'h0);
      chk("oor_st_rdata", rdata0, 32'h1234_5678);

      // Out-of-range load: err, rdata cleared
      sel = 1'b1; addr = 32'h0001_0000; set_req(1'b1, 1'b0);
      observe(5, 1'b0);
      chk("oor_ld_ack", o_ack_map, 32'h2);
      chk("oor_ld_err", o_err_map, 32'h2);
      chk("oor_ld_ce", o_ce_map, 32'h0);
      chk("oor_ld_rdata", o_rdata, 32'h0);

      // rd_en and wr_en together act as a store
      addr = 32'h10; set_req(1'b1, 1'b0);
      observe(6, 1'b0);
      chk("both_pre_rdata", rdata1, 32'h0000_BEEF);
      addr = 32'h8; wdata = 32'h1122_3344; bmask = 4'hF; set_req(1'b1, 1'b1);
      observe(6, 1'b0);
      chk("both_we_cycles", o_we_map, 32'h6);
      chk("both_ack_cycle", o_ack_map, 32'h8);
      chk("both_mem", mem1[2], 32'h1122_3344);
      chk("both_rdata", rdata1, 32'h0000_BEEF);

      // Reset in the middle of an access
      addr = 32'h30; wdata = 32'hAAAA_5555; set_req(1'b0, 1'b1);
      @(posedge clk); #1;
      chk("mid_ce_active", {31'h0, ce_n1}, 32'h0);
      rst_n = 1'b0; #1;
      chk("mid_rst_ce_we", {30'h0, ce_n1, we_n1}, 32'h3);
      chk("mid_rst_ack", {31'h0, ack1}, 32'h0);
      chk("mid_rst_rdata", rdata1, 32'h0);
      set_req(1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      observe(6, 1'b0);
      chk("mid_no_ack", o_ack_map, 32'h0);
      chk("mid_no_ce", o_ce_map, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
